// File: rtl/conv_encoder_punct_pkg.sv
// Shared types and constants for the 802.11a K=7 convolutional encoder.
// Puncturing to rates 2/3 and 3/4 is built only when CONV_PUNCTURE_EN is defined.
package conv_pkg;

    localparam int CONV_K = 7;
    localparam logic [CONV_K-1:0] CONV_G0 = 7'b1011011;
    localparam logic [CONV_K-1:0] CONV_G1 = 7'b1111001;

    typedef enum logic [1:0] {
        RATE_1_2 = 2'b00,
        RATE_2_3 = 2'b01,
        RATE_3_4 = 2'b10
    } rate_e;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'b00,
        ST_EMIT_A = 2'b01,
        ST_EMIT_B = 2'b10
    } state_e;

    // The unused code 11 falls back to the unpunctured rate.
    function automatic rate_e decode_rate(input logic [1:0] code);
        case (code)
            2'b01:   return RATE_2_3;
            2'b10:   return RATE_3_4;
            default: return RATE_1_2;
        endcase
    endfunction

    function automatic logic [1:0] group_size(input rate_e r);
        case (r)
            RATE_2_3: return 2'd2;
            RATE_3_4: return 2'd3;
            default:  return 2'd1;
        endcase
    endfunction

endpackage

// File: rtl/conv_encoder_punct_if.sv
// Serial bit-stream handshakes: uncoded input side and coded output side.
interface conv_encoder_punct_if;

    logic in_data;
    logic in_valid;
    logic in_ready;
    logic out_data;
    logic out_valid;
    logic out_ready;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

endinterface

// File: rtl/conv_encoder_punct_core.sv
// Combinational A/B generator outputs from the current bit and the past-bit register.
module conv_core
    import conv_pkg::*;
#(
    parameter int                        CONSTRAINT_LEN = CONV_K,
    parameter logic [CONSTRAINT_LEN-1:0] G0             = CONV_G0,
    parameter logic [CONSTRAINT_LEN-1:0] G1             = CONV_G1
) (
    input  logic                      bit_i,
    input  logic [CONSTRAINT_LEN-2:0] hist_i,
    output logic                      a_o,
    output logic                      b_o
);

    // hist_i MSB is the most recent past bit, so the window lines up with the tap masks.
    logic [CONSTRAINT_LEN-1:0] win;

    assign win = {bit_i, hist_i};
    assign a_o = ^(win & G0);
    assign b_o = ^(win & G1);

endmodule

// File: rtl/conv_encoder_punct.sv
// Rate-1/2 K=7 convolutional encoder with optional puncturing (CONV_PUNCTURE_EN) and one-bit output stream.
module conv_encoder_punct
    import conv_pkg::*;
#(
    parameter int                        CONSTRAINT_LEN = CONV_K,
    parameter logic [CONSTRAINT_LEN-1:0] G0             = CONV_G0,
    parameter logic [CONSTRAINT_LEN-1:0] G1             = CONV_G1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clear_i,
    input  logic [1:0]                rate_i,
    conv_encoder_punct_if.slave       strm
);

    localparam int SR_W = CONSTRAINT_LEN - 1;

    state_e            state_q, state_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic              out_q, out_d;
    logic              b_q, b_d;
    logic              b_keep_q, b_keep_d;
    logic              coded_a, coded_b;
    logic              keep_a, keep_b;
    logic              one_pending, in_xfer, out_xfer;

    conv_core #(
        .CONSTRAINT_LEN (CONSTRAINT_LEN),
        .G0             (G0),
        .G1             (G1)
    ) u_core (
        .bit_i  (strm.in_data),
        .hist_i (sr_q),
        .a_o    (coded_a),
        .b_o    (coded_b)
    );

`ifdef CONV_PUNCTURE_EN
    rate_e       rate_q, rate_d;
    logic [1:0]  phase_q, phase_d;

    always_comb begin
        keep_a = 1'b1;
        keep_b = 1'b1;
        case (rate_q)
            RATE_2_3: if (phase_q == 2'd1) keep_b = 1'b0;
            RATE_3_4: begin
                if (phase_q == 2'd1)      keep_b = 1'b0;
                else if (phase_q == 2'd2) keep_a = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        rate_d  = rate_q;
        phase_d = phase_q;
        if (clear_i) begin
            rate_d  = decode_rate(rate_i);
            phase_d = 2'd0;
        end else if (in_xfer) begin
            phase_d = (phase_q + 2'd1 == group_size(rate_q)) ? 2'd0 : phase_q + 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rate_q  <= RATE_1_2;
            phase_q <= 2'd0;
        end else begin
            rate_q  <= rate_d;
            phase_q <= phase_d;
        end
    end
`else
    logic unused_rate;

    assign unused_rate = ^rate_i;
    assign keep_a      = 1'b1;
    assign keep_b      = 1'b1;
`endif

    // A new bit may enter only when at most the final pending bit leaves this cycle.
    assign one_pending   = (state_q == ST_EMIT_B) || ((state_q == ST_EMIT_A) && !b_keep_q);
    assign strm.in_ready = !rst_i && !clear_i &&
                           ((state_q == ST_EMPTY) || (one_pending && strm.out_ready));
    assign in_xfer       = strm.in_valid && strm.in_ready;
    assign out_xfer      = (state_q != ST_EMPTY) && strm.out_ready;
    assign strm.out_valid = (state_q != ST_EMPTY);
    assign strm.out_data  = out_q;

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        out_d    = out_q;
        b_d      = b_q;
        b_keep_d = b_keep_q;
        if (clear_i) begin
            state_d  = ST_EMPTY;
            sr_d     = '0;
            out_d    = 1'b0;
            b_keep_d = 1'b0;
        end else if (in_xfer) begin
            sr_d = {strm.in_data, sr_q[SR_W-1:1]};
            if (keep_a) begin
                state_d  = ST_EMIT_A;
                out_d    = coded_a;
                b_d      = coded_b;
                b_keep_d = keep_b;
            end else begin
                state_d  = ST_EMIT_B;
                out_d    = coded_b;
                b_keep_d = 1'b0;
            end
        end else if (out_xfer) begin
            if ((state_q == ST_EMIT_A) && b_keep_q) begin
                state_d  = ST_EMIT_B;
                out_d    = b_q;
                b_keep_d = 1'b0;
            end else begin
                state_d  = ST_EMPTY;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_EMPTY;
            sr_q     <= '0;
            out_q    <= 1'b0;
            b_q      <= 1'b0;
            b_keep_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            out_q    <= out_d;
            b_q      <= b_d;
            b_keep_q <= b_keep_d;
        end
    end

endmodule

// File: tb/tb_conv_encoder_punct.sv
// Bench for conv_encoder_punct: directed impulses plus random frames against a polynomial/puncture-table model.
module tb_conv_encoder_punct;

  localparam bit [6:0] G0_OCT = 7'o133;
  localparam bit [6:0] G1_OCT = 7'o171;

  logic       clk;
  logic       rst;
  logic       clear;
  logic [1:0] rate;
  int         n_assert = 0;
  int         n_fail   = 0;
  bit         in_q[$];
  bit         exp_q[$];
  bit         got_q[$];

  conv_encoder_punct_if bus ();

  conv_encoder_punct dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .clear_i (clear),
    .rate_i  (rate),
    .strm    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // 0 = 1/2, 1 = 2/3, 2 = 3/4 as seen by the encoder after Clear.
  function automatic int eff_rate(input int code);
`ifdef CONV_PUNCTURE_EN
    return (code == 3) ? 0 : code;
`else
    return 0;
`endif
  endfunction

  function automatic void build_model(input int r);
    int period;
    bit pat_a[3];
    bit pat_b[3];
    bit a, b;
    case (r)
      1:       begin period = 2; pat_a = '{1, 1, 0}; pat_b = '{1, 0, 0}; end
      2:       begin period = 3; pat_a = '{1, 1, 0}; pat_b = '{1, 0, 1}; end
      default: begin period = 1; pat_a = '{1, 0, 0}; pat_b = '{1, 0, 0}; end
    endcase
    exp_q.delete();
    for (int n = 0; n < in_q.size(); n++) begin
      a = 0;
      b = 0;
      for (int k = 0; k < 7; k++) begin
        if (n - k >= 0) begin
          a ^= G0_OCT[6-k] & in_q[n-k];
          b ^= G1_OCT[6-k] & in_q[n-k];
        end
      end
      if (pat_a[n % period]) exp_q.push_back(a);
      if (pat_b[n % period]) exp_q.push_back(b);
    end
  endfunction

  function automatic logic [31:0] pack_got();
    logic [31:0] v;
    v = '0;
    foreach (got_q[i]) v = {v[30:0], got_q[i]};
    return v;
  endfunction

  task automatic do_clear(input logic [1:0] code);
    @(negedge clk);
    clear         = 1'b1;
    rate          = code;
    bus.in_valid  = 1'b1;
    bus.in_data   = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk("clear_in_ready", bus.in_ready, 1'b0);
    @(posedge clk);
    #1;
    chk("clear_out_valid", bus.out_valid, 1'b0);
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 1'b0;
  endtask

  // rmode: 0 ready always, 1 random ready/valid, 2 five-cycle stall at bit 3.
  task automatic run_frame(input int rcode, input int nin, input bit impulse,
                           input int rmode, input int abort_n, input bit tog);
    int k, idx, cyc, stall, limit;
    bit prev_hold, prev_data, prev_ir;
    in_q.delete();
    for (int i = 0; i < nin; i++)
      in_q.push_back(impulse ? (i == 0) : 1'($urandom_range(0, 1)));
    build_model(eff_rate(rcode));
    got_q.delete();
    limit = (abort_n > 0) ? abort_n : nin;
    k = 0; idx = 0; cyc = 0; stall = 0;
    prev_hold = 0; prev_data = 0; prev_ir = 0;
    while (1) begin
      @(negedge clk);
      if (rmode == 0) bus.out_ready = 1'b1;
      else if (rmode == 1) bus.out_ready = ($urandom_range(0, 3) != 0);
      else if (k == 3 && stall < 5) begin bus.out_ready = 1'b0; stall++; end
      else bus.out_ready = 1'b1;
      bus.in_valid = (idx < limit) && (rmode != 1 || $urandom_range(0, 3) != 0);
      bus.in_data  = (idx < nin) ? in_q[idx] : 1'b0;
      #1;
      if (prev_hold) begin
        chk("hold_valid", bus.out_valid, 1'b1);
        chk("hold_data", bus.out_data, prev_data);
      end
      if (bus.out_valid && !bus.out_ready) chk("stall_in_ready", bus.in_ready, 1'b0);
      if (tog && idx > 0 && idx < nin) chk("in_ready_toggle", bus.in_ready, !prev_ir);
      if (bus.out_valid && bus.out_ready) begin
        if (k < exp_q.size()) chk("coded_bit", bus.out_data, exp_q[k]);
        else chk("extra_bit", k + 1, exp_q.size());
        got_q.push_back(bus.out_data);
        k++;
      end
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
      prev_ir   = bus.in_ready;
      if (bus.in_valid && bus.in_ready) idx++;
      cyc++;
      @(posedge clk);
      if (abort_n > 0 && idx >= abort_n) break;
      if (abort_n == 0 && idx == nin && k == exp_q.size()) break;
      if (cyc > 4000) begin
        chk("frame_timeout", k, exp_q.size());
        break;
      end
    end
    bus.in_valid = 1'b0;
    if (abort_n == 0) begin
      @(negedge clk);
      #1;
      chk("no_extra_valid", bus.out_valid, 1'b0);
    end
  endtask

  initial begin
    rst           = 1'b1;
    clear         = 1'b0;
    rate          = 2'b00;
    bus.in_valid  = 1'b0;
    bus.in_data   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", bus.out_valid, 1'b0);
    chk("reset_out_data", bus.out_data, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", bus.in_ready, 1'b1);

    // Rate 1/2 impulse
    do_clear(2'b00);
    run_frame(0, 7, 1, 0, 0, 1);
    chk("impulse_r12_len", got_q.size(), 14);
    chk("impulse_r12_seq", pack_got(), 32'b11011111001011);

    // Rate 3/4 impulse
    do_clear(2'b10);
    run_frame(2, 9, 1, 0, 0, 0);
`ifdef CONV_PUNCTURE_EN
    chk("impulse_r34_len", got_q.size(), 12);
    chk("impulse_r34_seq", pack_got(), 32'b110111001100);
`else
    chk("impulse_r34_len", got_q.size(), 18);
    chk("impulse_r34_seq", pack_got(), 32'b110111110010110000);
`endif

    // Rate 2/3 impulse
    do_clear(2'b01);
    run_frame(1, 8, 1, 0, 0, 0);
`ifdef CONV_PUNCTURE_EN
    chk("impulse_r23_len", got_q.size(), 12);
    chk("impulse_r23_seq", pack_got(), 32'b110111001110);
`else
    chk("impulse_r23_len", got_q.size(), 16);
    chk("impulse_r23_seq", pack_got(), 32'b1101111100101100);
`endif

    // Backpressure on bit 3
    do_clear(2'b00);
    run_frame(0, 7, 1, 2, 0, 0);
    chk("stall_seq", pack_got(), 32'b11011111001011);

    // Clear mid-stream with B pending, then a clean impulse
    do_clear(2'b00);
    run_frame(0, 7, 1, 0, 3, 0);
    do_clear(2'b00);
    run_frame(0, 7, 1, 0, 0, 0);
    chk("after_clear_seq", pack_got(), 32'b11011111001011);

    // Random frames at every rate code with random handshakes
    for (int rc = 0; rc < 4; rc++) begin
      do_clear(2'(rc));
      run_frame(rc, 24, 0, 1, 0, 0);
    end

    // Rate change without Clear must be ignored
    do_clear(2'b00);
    rate = 2'b10;
    run_frame(0, 12, 0, 1, 0, 0);

    // Reset mid-stream at rate 3/4, then impulse without Clear
    do_clear(2'b10);
    run_frame(2, 12, 0, 1, 4, 0);
    @(negedge clk);
    rst           = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset_out_valid", bus.out_valid, 1'b0);
    chk("midreset_out_data", bus.out_data, 1'b0);
    @(negedge clk);
    rst  = 1'b0;
    rate = 2'b10;
    #1;
    chk("midreset_in_ready", bus.in_ready, 1'b1);
    run_frame(0, 7, 1, 0, 0, 0);
    chk("midreset_r12_seq", pack_got(), 32'b11011111001011);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
